prng_stream_checker: RTL

- Receive-side companion to the on-chip 8-bit PRNG. Consumes the PRNG's byte stream from an external loopback or a second die.
- Regenerates the expected sequence from the same 8-bit seed and compares each received byte against it.
- Reports lock status, mismatch events and a saturating error count.
- Serves as the self-test and characterisation end of the PRNG link.

---
 rtl/prng_stream_checker.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/prng_stream_checker.sv
// -----------------------------------------------------------------------------
// prng_stream_checker
//
// Receive-side checker for the on-chip 8-bit PRNG link. A local copy of the
// generator, seeded with the same 8-bit seed, regenerates the expected byte
// stream. Each received byte is compared against it. The block reports:
//   - lock status (ACQUIRE -> LOCKED -> LOST)
//   - a per-byte mismatch pulse
//   - a saturating error count
//
// Generator model, 16-bit state S:
//   expected byte E = rotl1(S[15:8]) ^ rotr1(S[7:0])
//   next state      = {S[14:0], S[15]^S[14]^S[12]^S[3]}
//
// Ports:
//   clk           system clock
//   rst_n         asynchronous active-low reset
//   start         single-cycle pulse. It loads {seed,seed}, clears the
//                 counters and enters ACQUIRE. A byte offered in the same
//                 cycle is dropped.
//   seed[7:0]     seed value, sampled only while start=1
//   in_valid      in_data carries a stream byte this cycle
//   in_data[7:0]  received PRNG byte
//   locked        high while the FSM is in LOCKED
//   lost          high while the FSM is in LOST
//   err_pulse     one-cycle pulse per mismatching accepted byte
//   err_count     mismatches seen in LOCKED. Saturates at all-ones.
//   byte_count    bytes accepted since the last start. Wraps modulo 2^16.
//   bit_err_count (only with PRNG_CHK_BITERR_EN) saturating 24-bit sum of
//                 popcount(in_data ^ E) over every accepted byte
//
// Optional feature macro: PRNG_CHK_BITERR_EN
// All outputs are registered. They update on the edge that accepts the byte.
// -----------------------------------------------------------------------------
module prng_stream_checker #(
  parameter int unsigned LOCK_N = 4,
  parameter int unsigned LOSS_N = 3,
  parameter int unsigned ERR_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [7:0]       seed,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             locked,
  output logic             lost,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic [15:0]      byte_count
`ifdef PRNG_CHK_BITERR_EN
  ,
  output logic [23:0]      bit_err_count
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2,
    LOST    = 2'd3
  } state_t;

  localparam logic [3:0] LOCK_LIM = 4'(LOCK_N);
  localparam logic [3:0] LOSS_LIM = 4'(LOSS_N);

  state_t           state_q, state_d;
  logic [15:0]      s_q, s_d;
  logic [3:0]       match_q, match_d;
  logic [3:0]       miss_q, miss_d;
  logic             err_pulse_d;
  logic [ERR_W-1:0] err_count_d;
  logic [15:0]      byte_count_d;

  logic [7:0]       s_hi, s_lo;
  logic [7:0]       exp_byte;
  logic [15:0]      s_next;
  logic             mismatch;

`ifdef PRNG_CHK_BITERR_EN
  logic [23:0]      bit_err_d;
  logic [24:0]      bit_sum;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction
`endif

  // Local copy of the generator.
  assign s_hi     = s_q[15:8];
  assign s_lo     = s_q[7:0];
  assign exp_byte = {s_hi[6:0], s_hi[7]} ^ {s_lo[0], s_lo[7:1]};
  assign s_next   = {s_q[14:0], s_q[15] ^ s_q[14] ^ s_q[12] ^ s_q[3]};
  assign mismatch = (in_data != exp_byte);

  // Next-state and next-output logic.
  always_comb begin
    // NOTE: every signal gets a default before any branch. A path that
    // leaves a signal unassigned would infer a latch.
    state_d      = state_q;
    s_d          = s_q;
    match_d      = match_q;
    miss_d       = miss_q;
    err_pulse_d  = 1'b0;
    err_count_d  = err_count;
    byte_count_d = byte_count;
`ifdef PRNG_CHK_BITERR_EN
    bit_err_d    = bit_err_count;
    bit_sum      = {1'b0, bit_err_count} + {21'd0, popcount8(in_data ^ exp_byte)};
`endif

    if (start) begin
      // start wins over a coincident byte. That byte is not accepted.
      state_d      = ACQUIRE;
      s_d          = {seed, seed};
      match_d      = '0;
      miss_d       = '0;
      err_count_d  = '0;
      byte_count_d = '0;
`ifdef PRNG_CHK_BITERR_EN
      bit_err_d    = '0;
`endif
    end else if (in_valid && (state_q != IDLE)) begin
      s_d          = s_next;
      byte_count_d = byte_count + 16'd1;
      err_pulse_d  = mismatch;
`ifdef PRNG_CHK_BITERR_EN
      bit_err_d    = bit_sum[24] ? '1 : bit_sum[23:0];
`endif
      unique case (state_q)
        ACQUIRE: begin
          if (mismatch) begin
            match_d = '0;
          end else begin
            match_d = match_q + 4'd1;
            if (match_q + 4'd1 == LOCK_LIM) begin
              state_d = LOCKED;
              miss_d  = '0;
            end
          end
        end
        LOCKED: begin
          if (!mismatch) begin
            miss_d = '0;
          end else begin
            if (err_count != '1) err_count_d = err_count + ERR_W'(1);
            miss_d = miss_q + 4'd1;
            if (miss_q + 4'd1 == LOSS_LIM) state_d = LOST;
          end
        end
        default: ; // LOST keeps tracking the stream and only pulses on errors.
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only. All flops
  // then sample their inputs from the same point in time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      s_q           <= '0;
      match_q       <= '0;
      miss_q        <= '0;
      locked        <= 1'b0;
      lost          <= 1'b0;
      err_pulse     <= 1'b0;
      err_count     <= '0;
      byte_count    <= '0;
`ifdef PRNG_CHK_BITERR_EN
      bit_err_count <= '0;
`endif
    end else begin
      state_q       <= state_d;
      s_q           <= s_d;
      match_q       <= match_d;
      miss_q        <= miss_d;
      locked        <= (state_d == LOCKED);
      lost          <= (state_d == LOST);
      err_pulse     <= err_pulse_d;
      err_count     <= err_count_d;
      byte_count    <= byte_count_d;
`ifdef PRNG_CHK_BITERR_EN
      bit_err_count <= bit_err_d;
`endif
    end
  end

endmodule
